// File: rtl/simple_cpu_gen2_pkg.sv
// Shared types and field positions for the simple_cpu_gen2 core.
// Opcodes, FSM states, instruction field layout and the shift helper.
package simple_cpu_gen2_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NAND = 3'd1,
    OP_SRL  = 3'd2,
    OP_LT   = 3'd3,
    OP_CP   = 3'd4,
    OP_CPI  = 3'd5,
    OP_BZJ  = 3'd6,
    OP_MUL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RDB    = 3'd2,
    S_IND    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int OP_LO   = 29;
  localparam int IMM_BIT = 28;
  localparam int A_LO    = 14;
  localparam int B_LO    = 0;
  localparam int FIELD_W = 14;

  // Amounts 0..31 shift right, 32..63 shift left by s-32, larger give 0.
  function automatic logic [31:0] srl32(
    input logic [31:0] v,
    input logic [31:0] s
  );
    if (|s[31:6]) return '0;
    return s[5] ? (v << s[4:0]) : (v >> s[4:0]);
  endfunction

endpackage

// File: rtl/simple_cpu_gen2_alu.sv
// Combinational ALU for the simple_cpu_gen2 core.
// Produces the write-back value and whether it should be written.
module simple_cpu_gen2_alu
  import simple_cpu_gen2_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  op_e         op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o,
  output logic        we_o
);

  always_comb begin
    res_o = '0;
    we_o  = 1'b1;
    unique case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_NAND: res_o = ~(a_i & b_i);
      OP_SRL:  res_o = srl32(a_i, b_i);
      OP_LT:   res_o = {31'd0, a_i < b_i};
      OP_CP:   res_o = b_i;
      OP_MUL: begin
        if (MUL_EN) res_o = a_i * b_i;
        else        we_o  = 1'b0;
      end
      default: we_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/simple_cpu_gen2.sv
// Multi-cycle SimpleCPU core sharing one RAM port with a ready handshake.
// Read data arrives the cycle after acceptance and is held across stalls.
module simple_cpu_gen2
  import simple_cpu_gen2_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_fromRAM,
  input  logic              mem_ready,
  output logic              wrEn,
  output logic [ADDR_W-1:0] addr_toRAM,
  output logic [31:0]       data_toRAM,
  output logic [ADDR_W-1:0] pCounter,
  output logic              retired,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, opa_q, rdata_q;
  logic              fresh_q;

  logic [31:0]       rd, ir, bimm;
  logic [31:0]       ex_a, ex_b, alu_res;
  op_e               op;
  logic              imm, imm_path, alu_we, go;
  logic [ADDR_W-1:0] fa, fb, pc_inc, tgt, addr_c;
  logic              we_c;
  logic [31:0]       wdata_c;
  logic              unused_afield;

  // Bus data is only valid right after an accepted request.
  assign rd = fresh_q ? data_fromRAM : rdata_q;
  assign ir = (state_q == S_DECODE) ? rd : ir_q;

  assign op   = op_e'(ir[OP_LO +: 3]);
  assign imm  = ir[IMM_BIT];
  assign fa   = ir[A_LO +: ADDR_W];
  assign fb   = ir[B_LO +: ADDR_W];
  assign bimm = 32'(ir[B_LO +: FIELD_W]);

  assign unused_afield = ^ir[A_LO +: FIELD_W];

  // CPIi takes the register path although its imm bit is set.
  assign imm_path = imm & (op != OP_CPI);
  assign ex_a     = imm_path ? rd : opa_q;
  assign ex_b     = imm_path ? bimm : rd;
  assign pc_inc   = pc_q + 1'b1;
  assign tgt      = ADDR_W'(ex_a + ex_b);

  simple_cpu_gen2_alu #(
    .MUL_EN(MUL_EN)
  ) u_alu (
    .op_i (op),
    .a_i  (ex_a),
    .b_i  (ex_b),
    .res_o(alu_res),
    .we_o (alu_we)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_c  = '0;
    we_c    = 1'b0;
    wdata_c = '0;
    go      = mem_ready;
    unique case (state_q)
      S_FETCH: begin
        addr_c  = pc_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        addr_c = (op == OP_CPI && !imm) ? fb : fa;
        if (op == OP_CPI) state_d = imm ? S_RDB : S_IND;
        else              state_d = imm ? S_EXEC : S_RDB;
      end
      S_RDB: begin
        addr_c  = fb;
        state_d = S_EXEC;
      end
      S_IND: begin
        addr_c  = rd[ADDR_W-1:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        addr_c  = fa;
        pc_d    = pc_inc;
        state_d = S_FETCH;
        unique case (1'b1)
          op == OP_BZJ: begin
            if (imm) begin
              pc_d = tgt;
              if (tgt == pc_q) state_d = S_HALT;
            end else if (ex_b == '0) begin
              pc_d = opa_q[ADDR_W-1:0];
            end
          end
          op == OP_CPI: begin
            we_c    = 1'b1;
            wdata_c = ex_b;
            if (imm) addr_c = opa_q[ADDR_W-1:0];
          end
          default: begin
            we_c    = alu_we;
            wdata_c = alu_res;
          end
        endcase
      end
      S_HALT: addr_c = pc_q;
      default: begin
        state_d = S_FETCH;
        pc_d    = '0;
        go      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opa_q   <= '0;
      rdata_q <= '0;
      fresh_q <= 1'b0;
    end else begin
      fresh_q <= mem_ready;
      rdata_q <= rd;
      if (go) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        if (state_q == S_DECODE) ir_q <= rd;
        if (state_q == S_RDB) opa_q <= rd;
      end
    end
  end

  assign wrEn       = we_c & ~rst;
  assign addr_toRAM = rst ? '0 : addr_c;
  assign data_toRAM = (we_c & ~rst) ? wdata_c : '0;
  assign pCounter   = pc_q;
  assign retired    = (state_q == S_EXEC) & mem_ready & ~rst;
  assign halted     = (state_q == S_HALT);

endmodule
